// File: rtl/serial_tx.sv
// serial_tx: start/data(LSB first)/stop serializer; define SERIAL_TX_PARITY_EN to add an even-parity bit
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_q,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int NXT = DATA_WIDTH > 1 ? 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic ONE = (CLKS_PER_BIT == 1);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef SERIAL_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_sh;
  logic                  r_q, r_ready, r_busy, r_done;
`ifdef SERIAL_TX_PARITY_EN
  logic                  r_par;
`endif
  logic                  w_last;
  assign w_last  = (r_cnt == LAST);
  assign o_q     = r_q;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  // Frame sequencer; outputs are loaded with the value they must show in the cycle after each edge,
  // so o_done rises on the edge that enters the final stop-bit cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_q     <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (i_valid) begin
          r_sh    <= i_data;
`ifdef SERIAL_TX_PARITY_EN
          r_par   <= ^i_data;
`endif
          r_state <= S_START;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_q     <= 1'b0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
        S_START: if (w_last) begin
          r_state <= S_DATA;
          r_cnt   <= '0;
          r_q     <= r_sh[0];
        end else r_cnt <= r_cnt + 1'b1;
        S_DATA: if (w_last) begin
          r_cnt <= '0;
          r_sh  <= r_sh >> 1;
          if (r_bit == LAST_BIT) begin
            r_bit   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_state <= S_PARITY;
            r_q     <= r_par;
`else
            r_state <= S_STOP;
            r_q     <= 1'b1;
            r_done  <= ONE;
`endif
          end else begin
            r_bit <= r_bit + 1'b1;
            r_q   <= r_sh[NXT];
          end
        end else r_cnt <= r_cnt + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: if (w_last) begin
          r_state <= S_STOP;
          r_cnt   <= '0;
          r_q     <= 1'b1;
          r_done  <= ONE;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        S_STOP: if (w_last) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_q     <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_done <= (r_cnt == PRE);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: queue-based line model plus directed frame, back-to-back, busy, reset and parity vectors
module tb_serial_tx;
  localparam int DW = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  logic          clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          rdy, q, busy, done;
  int            tests = 0, fails = 0, cyc = 0;
  int            acc[$];
  bit            mq[$];
  logic          prev_rdy = 1'b1;
  logic          qs[0:63], ds[0:63], rs[0:63];
  logic [9:0]    pat;

  always #5 clk = ~clk;

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(rdy), .o_q(q), .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Line value of frame slot s: 0 = start, 1..DW = data LSB first, then parity (if enabled), then stop
  function automatic bit fbit(input int s, input logic [DW-1:0] d);
    if (s == 0) return 1'b0;
    if (s <= DW) return d[s-1];
    if (s == DW + 1 && NB == DW + 3) return ^d;
    return 1'b1;
  endfunction

  // Model: an idle transmitter takes a valid word and queues one entry per line cycle
  always @(posedge clk or posedge rst) begin
    if (rst) mq.delete();
    else if (mq.size() == 0) begin
      if (valid) for (int s = 0; s < NB; s++) for (int c = 0; c < CPB; c++) mq.push_back(fbit(s, data));
    end else void'(mq.pop_front());
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int expv();
    if (mq.size() == 0) return 4'b1010;
    return {mq[0], 1'b1, 1'b0, mq.size() == 1};
  endfunction

  // Compare {q,busy,ready,done} against the model every cycle
  always @(negedge clk) chk("line{q,busy,ready,done}", {q, busy, rdy, done}, expv());

  // Acceptance stamps from the falling edge of o_ready
  always @(negedge clk) begin
    if (prev_rdy && !rdy) acc.push_back(cyc);
    prev_rdy <= rdy;
  end

  task automatic rec(input int n);
    for (int k = 1; k <= n; k++) begin
      qs[k] = q; ds[k] = done; rs[k] = rdy;
      @(negedge clk);
    end
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc.size() < n && t < 200) begin @(negedge clk); t++; end
    if (acc.size() < n) begin
      tests++; fails++;
      $display("FAIL acceptance_timeout: got %0d acceptances expected %0d", acc.size(), n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!rdy && t < 200) begin @(negedge clk); t++; end
    chk("idle_reached", rdy, 1);
    @(negedge clk);
  endtask

  initial begin
    int n0, c0, nd;
    #2 rst = 1'b1;
    #1;
    chk("rst_q", q, 1); chk("rst_ready", rdy, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifndef SERIAL_TX_PARITY_EN
    pat = 10'b1101001010;
    valid = 1'b1; data = 8'hA5;
    @(negedge clk);
    valid = 1'b0;
    rec(41);
    for (int s = 0; s < 10; s++)
      for (int c = 1; c <= 4; c++) chk($sformatf("a5_slot%0d_c%0d", s, c), qs[4*s+c], pat[s]);
    nd = 0;
    for (int k = 1; k <= 41; k++) nd += ds[k];
    chk("a5_done_count", nd, 1);
    chk("a5_done_c40", ds[40], 1);
    chk("a5_ready_c40", rs[40], 0);
    chk("a5_ready_c41", rs[41], 1);
    n0 = acc.size();
    data = 8'h3C; valid = 1'b1;
    wait_acc(n0 + 1);
    data = 8'hC3;
    wait_acc(n0 + 2);
    valid = 1'b0;
    chk("b2b_gap", acc[n0+1] - acc[n0], 41);
    wait_idle();
    n0 = acc.size();
    data = 8'h0F; valid = 1'b1;
    wait_acc(n0 + 1);
    data = 8'hFF;
    wait_acc(n0 + 2);
    valid = 1'b0;
    chk("busy_gap", acc[n0+1] - acc[n0], 41);
    wait_idle();
    data = 8'h00; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_q_bit3", q, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", q, 1); chk("mid_rst_ready", rdy, 1); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    repeat (3) begin @(negedge clk); chk("rst_hold_q", q, 1); end
    rst = 1'b0; data = 8'h55; valid = 1'b1;
    c0 = cyc;
    n0 = acc.size();
    wait_acc(n0 + 1);
    valid = 1'b0;
    chk("post_rst_accept", acc[n0] - c0, 1);
    wait_idle();
`else
    for (int i = 0; i < 2; i++) begin
      data = (i == 0) ? 8'h07 : 8'h03;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      rec(45);
      for (int c = 37; c <= 40; c++) chk($sformatf("par%0d_c%0d", i, c), qs[c], (i == 0) ? 1 : 0);
      nd = 0;
      for (int k = 1; k <= 45; k++) nd += ds[k];
      chk("par_done_count", nd, 1);
      chk("par_done_c44", ds[44], 1);
      chk("par_ready_c45", rs[45], 1);
      chk("par_stop_c44", qs[44], 1);
    end
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of payload bits per frame (>=1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (>=1).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_data  input  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL have port i_valid  input  1  i_data valid, requesting a transfer.
REQ-007 SHALL have port o_ready  output  1  transmitter can accept a word this cycle.
REQ-008 SHALL have port o_q  output  1  serial line; idle level 1.
REQ-009 SHALL have port o_busy  output  1  high while a frame is on the line.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse marking the last cycle of a frame.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (only when the Configuration macro is defined) and STOP, with all outputs registered.
REQ-012 SHALL drive o_ready=1 only in IDLE, and o_busy=1 in every state except IDLE.
REQ-013 SHALL accept a word when i_valid=1 and o_ready=1 at a rising edge: i_data latched into an internal shift register, IDLE->START.
REQ-014 SHALL ignore i_valid and i_data in all non-IDLE states; changes to i_data after acceptance SHALL NOT affect the frame.
REQ-015 SHALL begin the start bit (o_q=0) in the cycle after acceptance.
REQ-016 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-period counter of width max(1,$clog2(CLKS_PER_BIT)).
REQ-017 SHALL send the start bit (0), then DATA_WIDTH data bits LSB first, then the optional parity bit, then one stop bit (1).
REQ-018 SHALL count data bits with a counter that wraps to 0 on entering STOP/PARITY; no bit SHALL be sent twice or skipped.
REQ-019 SHALL assert o_done for exactly one cycle, coincident with the final cycle of the stop bit, then return to IDLE (o_ready=1) on the next cycle.
REQ-020 SHALL keep o_q=1 in IDLE; with i_valid held high, consecutive frames SHALL be separated by exactly one idle cycle.
REQ-021 SHALL take exactly NBITS*CLKS_PER_BIT+1 cycles from one acceptance to the next under continuous i_valid, where NBITS = DATA_WIDTH+2 (+1 with parity).
REQ-022 SHALL behave correctly at CLKS_PER_BIT=1 (one bit per clock, no idle cycle within a frame).

Reset
REQ-023 SHALL, while i_rst=1 and independent of i_clk, force state IDLE, o_q=1, o_ready=1, o_busy=0, o_done=0, and clear all counters and the shift register.
REQ-024 SHALL abort a frame in progress on reset without emitting any further bits; no handshake SHALL be accepted while i_rst=1.
REQ-025 SHALL accept a new word at the first rising edge after i_rst deasserts if i_valid=1.

Configuration
REQ-026 SHALL, when SERIAL_TX_PARITY_EN is defined, insert an even-parity bit (XOR of the latched data bits) between the last data bit and the stop bit, for CLKS_PER_BIT cycles.
REQ-027 SHALL, when SERIAL_TX_PARITY_EN is undefined, omit the PARITY state and the parity logic, with frame length DATA_WIDTH+2 bits.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4, macro undefined unless stated)
REQ-028 SHALL cover reset: assert i_rst between edges -> o_q=1, o_ready=1, o_busy=0, o_done=0 immediately.
REQ-029 SHALL cover a single frame: 0xA5 accepted -> o_q per 4-cycle slot = 0,1,0,1,0,0,1,0,1,1; o_done high only in cycle 40 after acceptance; o_ready=1 in cycle 41.
REQ-030 SHALL cover back-to-back: i_valid held high, 0x3C then 0xC3 -> second acceptance exactly 41 cycles after first; both frames bit-exact.
REQ-031 SHALL cover busy input: 0x0F accepted, i_data=0xFF with i_valid=1 during the frame -> line carries 0x0F only; 0xFF accepted at the next o_ready=1.
REQ-032 SHALL cover reset mid-frame: i_rst during data bit 3 -> o_q=1 at once, no further 0 bits; a new word 0x55 afterwards transmits cleanly.
REQ-033 SHALL cover parity with SERIAL_TX_PARITY_EN defined: 0x07 -> parity slot 1; 0x03 -> parity slot 0; frame is 44 cycles and o_done in cycle 44.
